// File: rtl/pieo_eligibility_tracker.sv
// pieo_eligibility_tracker
//   Slot table for the PIEO dequeue path. Each slot holds an occupied bit and
//   an eligibility timestamp. Every cycle the block publishes a registered
//   bitmap of slots that are occupied and whose time has been reached. The
//   priority encoder that picks the dequeue slot consumes this bitmap.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   s_insert_valid    insert request from the enqueue logic
//   s_insert_ready    combinational: the insert is taken this cycle if valid
//   s_insert_slot     slot to fill
//   s_insert_time     earliest eligible time for that slot
//   s_clear_valid     clear (dequeue-done) request, always accepted
//   s_clear_slot      slot to free
//   now_time          scheduler time, wraps modulo 2^TIME_WIDTH
//   eligible_vec      registered bitmap of eligible slots
//   occupied_vec      registered bitmap of occupied slots (the table itself)
//   eligible_any      registered OR of eligible_vec
//   occ_count         number of occupied slots
//   err_clear_empty   one-cycle pulse: clear of an empty or out-of-range slot
module pieo_eligibility_tracker #(
  parameter int SLOTS      = 64,
  parameter int TIME_WIDTH = 32,
  localparam int IDX_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_insert_valid,
  output logic                  s_insert_ready,
  input  logic [IDX_W-1:0]      s_insert_slot,
  input  logic [TIME_WIDTH-1:0] s_insert_time,
  input  logic                  s_clear_valid,
  input  logic [IDX_W-1:0]      s_clear_slot,
  input  logic [TIME_WIDTH-1:0] now_time,
  output logic [SLOTS-1:0]      eligible_vec,
  output logic [SLOTS-1:0]      occupied_vec,
  output logic                  eligible_any,
  output logic [IDX_W:0]        occ_count,
  output logic                  err_clear_empty
);

  localparam logic [IDX_W:0] SLOT_LIMIT = (IDX_W + 1)'(SLOTS);

  logic [TIME_WIDTH-1:0] time_r [SLOTS];

  logic                  ins_in_range_s;
  logic                  clr_in_range_s;
  logic                  ins_slot_occ_s;
  logic                  clr_slot_occ_s;
  logic                  same_slot_s;
  logic                  ins_fire_s;
  logic                  clr_fire_s;
  logic [SLOTS-1:0]      ins_hit_s;
  logic [SLOTS-1:0]      clr_hit_s;
  logic [SLOTS-1:0]      occ_next_s;
  logic [SLOTS-1:0]      elig_next_s;
  logic [TIME_WIDTH-1:0] time_next_s [SLOTS];
  logic [TIME_WIDTH-1:0] age_s [SLOTS];
  logic [IDX_W:0]        count_next_s;

  // Request decode: range checks, occupancy of the addressed slots, handshake.
  always_comb begin
    ins_in_range_s = ({1'b0, s_insert_slot} < SLOT_LIMIT);
    clr_in_range_s = ({1'b0, s_clear_slot} < SLOT_LIMIT);
    ins_slot_occ_s = 1'b0;
    clr_slot_occ_s = 1'b0;
    // Out-of-range indices match no slot, so they read as empty here and
    // are rejected by the range terms below.
    for (int i = 0; i < SLOTS; i++) begin
      ins_slot_occ_s = ins_slot_occ_s | (occupied_vec[i] & (s_insert_slot == IDX_W'(i)));
      clr_slot_occ_s = clr_slot_occ_s | (occupied_vec[i] & (s_clear_slot == IDX_W'(i)));
    end
    same_slot_s    = s_clear_valid & (s_clear_slot == s_insert_slot);
    // A same-cycle clear of the target slot frees it before the insert lands.
    s_insert_ready = ins_in_range_s & (~ins_slot_occ_s | same_slot_s);
    ins_fire_s     = s_insert_valid & s_insert_ready;
    clr_fire_s     = s_clear_valid & clr_in_range_s & clr_slot_occ_s;
  end

  // Next table state (clear first, then insert) and eligibility from it.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      ins_hit_s[i]   = ins_fire_s & (s_insert_slot == IDX_W'(i));
      clr_hit_s[i]   = clr_fire_s & (s_clear_slot == IDX_W'(i));
      occ_next_s[i]  = (occupied_vec[i] & ~clr_hit_s[i]) | ins_hit_s[i];
      time_next_s[i] = ins_hit_s[i] ? s_insert_time : time_r[i];
      // Wrap-aware compare: reached when (now - time) lies in the lower half
      // of the modular range, i.e. its top bit is clear.
      age_s[i]       = now_time - time_next_s[i];
      elig_next_s[i] = occ_next_s[i] & ~age_s[i][TIME_WIDTH-1];
    end
    // An insert only fires into an empty slot (or one cleared this cycle),
    // so the count moves by exactly +insert -clear.
    count_next_s = occ_count + (IDX_W + 1)'(ins_fire_s) - (IDX_W + 1)'(clr_fire_s);
  end

  // Table, published bitmaps, count and error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupied_vec    <= '0;
      eligible_vec    <= '0;
      eligible_any    <= 1'b0;
      occ_count       <= '0;
      err_clear_empty <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        time_r[i] <= '0;
      end
    end else begin
      occupied_vec    <= occ_next_s;
      eligible_vec    <= elig_next_s;
      eligible_any    <= |elig_next_s;
      occ_count       <= count_next_s;
      err_clear_empty <= s_clear_valid & ~clr_fire_s;
      for (int i = 0; i < SLOTS; i++) begin
        time_r[i] <= time_next_s[i];
      end
    end
  end

endmodule

// File: tb/tb_pieo_eligibility_tracker.sv
module tb_pieo_eligibility_tracker;

  localparam int SLOTS = 12;
  localparam int TW    = 8;
  localparam int IDX_W = 4;

  logic             clk;
  logic             rst;
  logic             s_insert_valid;
  logic             s_insert_ready;
  logic [IDX_W-1:0] s_insert_slot;
  logic [TW-1:0]    s_insert_time;
  logic             s_clear_valid;
  logic [IDX_W-1:0] s_clear_slot;
  logic [TW-1:0]    now_time;
  logic [SLOTS-1:0] eligible_vec;
  logic [SLOTS-1:0] occupied_vec;
  logic             eligible_any;
  logic [IDX_W:0]   occ_count;
  logic             err_clear_empty;

  int checks   = 0;
  int failures = 0;

  // Reference model: plain arrays and integers.
  bit m_occ [SLOTS];
  int m_time[SLOTS];
  int m_cnt;
  bit m_err;
  int m_now;

  pieo_eligibility_tracker #(.SLOTS(SLOTS), .TIME_WIDTH(TW)) dut (
    .clk(clk), .rst(rst),
    .s_insert_valid(s_insert_valid), .s_insert_ready(s_insert_ready),
    .s_insert_slot(s_insert_slot), .s_insert_time(s_insert_time),
    .s_clear_valid(s_clear_valid), .s_clear_slot(s_clear_slot),
    .now_time(now_time),
    .eligible_vec(eligible_vec), .occupied_vec(occupied_vec),
    .eligible_any(eligible_any), .occ_count(occ_count),
    .err_clear_empty(err_clear_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_occ(input int slot);
    if (slot >= 0 && slot < SLOTS) return m_occ[slot];
    return 1'b0;
  endfunction

  function automatic logic [SLOTS-1:0] model_occ_vec();
    logic [SLOTS-1:0] v = '0;
    for (int i = 0; i < SLOTS; i++) v[i] = m_occ[i];
    return v;
  endfunction

  // Eligible when the modular distance from the stored time to now is
  // below half the 256-value time range.
  function automatic logic [SLOTS-1:0] model_elig_vec();
    logic [SLOTS-1:0] v = '0;
    for (int i = 0; i < SLOTS; i++)
      v[i] = m_occ[i] && (((m_now - m_time[i] + 256) % 256) < 128);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SLOTS; i++) begin
      m_occ[i]  = 1'b0;
      m_time[i] = 0;
    end
    m_cnt = 0;
    m_err = 1'b0;
    m_now = 0;
  endtask

  // One clock cycle: drive, check ready, clock, update model, check outputs.
  task automatic step(input bit iv, input int islot, input int itime,
                      input bit cv, input int cslot, input int now);
    bit exp_rdy;
    bit accept;
    s_insert_valid = iv;
    s_insert_slot  = islot[IDX_W-1:0];
    s_insert_time  = itime[TW-1:0];
    s_clear_valid  = cv;
    s_clear_slot   = cslot[IDX_W-1:0];
    now_time       = now[TW-1:0];
    #1;
    exp_rdy = (islot < SLOTS) && (!model_occ(islot) || (cv && cslot == islot));
    chk("insert_ready", s_insert_ready, exp_rdy);
    accept = iv && exp_rdy;
    @(posedge clk);
    m_err = 1'b0;
    if (cv) begin
      if (model_occ(cslot)) begin
        m_occ[cslot] = 1'b0;
        m_cnt--;
      end else begin
        m_err = 1'b1;
      end
    end
    if (accept) begin
      m_occ[islot]  = 1'b1;
      m_time[islot] = itime % 256;
      m_cnt++;
    end
    m_now = now % 256;
    #1;
    chk("occupied_vec", occupied_vec, model_occ_vec());
    chk("eligible_vec", eligible_vec, model_elig_vec());
    chk("eligible_any", eligible_any, |model_elig_vec());
    chk("occ_count", occ_count, m_cnt);
    chk("err_clear_empty", err_clear_empty, m_err);
  endtask

  initial begin
    int saved_cnt;
    int now;
    rst = 1'b1;
    s_insert_valid = 1'b0; s_insert_slot = '0; s_insert_time = '0;
    s_clear_valid  = 1'b0; s_clear_slot  = '0; now_time      = '0;
    model_reset();
    #1;
    chk("reset_occ", occupied_vec, 0);
    chk("reset_elig", eligible_vec, 0);
    chk("reset_count", occ_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // T1: async reset mid-traffic with 5 slots occupied
    for (int i = 0; i < 5; i++) step(1'b1, i, 10 * i, 1'b0, 0, 50);
    chk("t1_count5", occ_count, 5);
    rst = 1'b1;
    #1;
    model_reset();
    chk("t1_rst_occ", occupied_vec, 0);
    chk("t1_rst_elig", eligible_vec, 0);
    chk("t1_rst_any", eligible_any, 0);
    chk("t1_rst_count", occ_count, 0);
    chk("t1_rst_err", err_clear_empty, 0);
    #1 rst = 1'b0;
    s_insert_valid = 1'b0; s_clear_valid = 1'b0; s_insert_slot = '0;
    #1;
    chk("t1_ready_slot0", s_insert_ready, 1);

    // T2: eligibility
    step(1'b1, 3, 100, 1'b0, 0, 100);
    step(1'b1, 7, 150, 1'b0, 0, 100);
    chk("t2_elig", eligible_vec, 12'h008);
    chk("t2_occ", occupied_vec, 12'h088);
    step(1'b0, 0, 0, 1'b0, 0, 150);
    chk("t2_elig_later", eligible_vec, 12'h088);
    chk("t2_any", eligible_any, 1);

    // T3: wrap of the 8-bit time
    step(1'b0, 0, 0, 1'b1, 3, 150);
    step(1'b0, 0, 0, 1'b1, 7, 150);
    step(1'b1, 0, 4, 1'b0, 0, 250);
    chk("t3_not_elig", eligible_vec[0], 0);
    for (int n = 251; n <= 259; n++) step(1'b0, 0, 0, 1'b0, 0, n % 256);
    chk("t3_before_wrap_elig", eligible_vec[0], 0);
    step(1'b0, 0, 0, 1'b0, 0, 4);
    chk("t3_wrap_elig", eligible_vec[0], 1);

    // T4: same-slot clear + insert race
    step(1'b0, 0, 0, 1'b1, 0, 20);
    step(1'b1, 5, 10, 1'b0, 0, 20);
    saved_cnt = m_cnt;
    step(1'b1, 5, 30, 1'b1, 5, 20);
    chk("t4_occ5", occupied_vec[5], 1);
    chk("t4_elig5", eligible_vec[5], 0);
    chk("t4_count", occ_count, saved_cnt);

    // T5: backpressure and clear of an empty slot
    step(1'b1, 2, 0, 1'b0, 0, 20);
    step(1'b1, 2, 99, 1'b0, 0, 20);
    chk("t5_time_kept", eligible_vec[2], 1);
    saved_cnt = m_cnt;
    step(1'b0, 0, 0, 1'b1, 9, 20);
    chk("t5_err_pulse", err_clear_empty, 1);
    chk("t5_count", occ_count, saved_cnt);
    step(1'b0, 0, 0, 1'b0, 0, 20);
    chk("t5_err_gone", err_clear_empty, 0);
    step(1'b0, 0, 0, 1'b1, 14, 20);
    chk("t5_err_oob", err_clear_empty, 1);

    // T6: full table
    for (int i = 0; i < SLOTS; i++) step(1'b1, i, i, 1'b0, 0, 20);
    chk("t6_full", occ_count, SLOTS);
    step(1'b1, 13, 0, 1'b0, 0, 20);
    chk("t6_oob_ready", s_insert_ready, 0);
    step(1'b1, 4, 7, 1'b1, 4, 20);
    chk("t6_swap_count", occ_count, SLOTS);

    // Randomized traffic against the model
    now = 20;
    for (int k = 0; k < 400; k++) begin
      now = (now + $urandom_range(0, 3)) % 256;
      step($urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 255),
           $urandom_range(0, 2) == 0, $urandom_range(0, 15), now);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
